mem_access: RTL and testbench

Memory-access stage of the rv32i pipeline, between execute and `pre_wb`. It takes one execute-stage instruction at a time and drives the data-memory request/acknowledge bus for loads and stores. It formats load data (byte/half extraction, sign/zero extension) and presents registered `alu_out`, `mem_data_out`, `mem_re`, `reg_we` and `reg_addr` to `pre_wb`. While a bus access is outstanding it stalls execute through `ex_ready`.

---
 rtl/mem_access.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_access.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage of the rv32i pipeline: drives the data-memory
// request/acknowledge bus for loads and stores, formats load data and
// hands registered results to pre_wb. Execute is stalled while an access
// is outstanding.
module mem_access #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_mem_re,
   input  logic        ex_mem_we,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_store_data,
   input  logic        ex_reg_we,
   input  logic [4:0]  ex_reg_addr,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        out_valid,
   output logic        mem_re,
   output logic        reg_we,
   output logic [31:0] alu_out,
   output logic [31:0] mem_data_out,
   output logic [4:0]  reg_addr,
   output logic        misalign_err,
   output logic        bus_err
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   // Result of an instruction that retires without a bus access.
   typedef struct packed {
      logic [31:0] alu;
      logic        reg_we;
      logic [4:0]  reg_addr;
      logic        misalign;
   } imm_t;

   // Last BUSY cycle index: the counter has seen ACK_TIMEOUT-1 silent cycles.
   localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

   state_e      state_q;
   logic [7:0]  cnt_q;
   logic [31:0] addr_q;
   logic [2:0]  f3_q;
   logic        is_load_q;
   logic        cap_reg_we_q;
   logic [4:0]  cap_reg_addr_q;
   logic        pend_q;
   imm_t        pend_rec_q;

   logic        dmem_req_q, dmem_we_q;
   logic [31:0] dmem_addr_q, dmem_wdata_q;
   logic [3:0]  dmem_be_q;
   logic        out_valid_q, mem_re_q, reg_we_q, misalign_q, bus_err_q;
   logic [31:0] alu_out_q, mem_data_out_q;
   logic [4:0]  reg_addr_q;

   logic        accept, busy_done;
   logic        acc_mem, acc_store, acc_legal;
   logic [3:0]  acc_be_d;
   logic [31:0] acc_wdata_d;
   imm_t        imm_rec_d;
   logic [31:0] lane_d, ld_data_d;

   // A BUSY access ends this cycle (ack wins over timeout); execute may hand
   // over the next instruction in that same cycle.
   assign busy_done = (state_q == S_BUSY) && (dmem_ack || (cnt_q == TO_LAST));
   assign ex_ready  = (state_q == S_IDLE) ? ~pend_q : busy_done;
   assign accept    = ex_valid && ex_ready;

   // A load with the store bit also set is treated as a plain load.
   assign acc_mem   = ex_mem_re | ex_mem_we;
   assign acc_store = ex_mem_we & ~ex_mem_re;

   // Decode legality, byte enables and lane-replicated write data at acceptance.
   always_comb begin
      // NOTE: every signal driven here is given a default first, so no path leaves it unassigned and no latch is inferred.
      acc_legal   = 1'b0;
      acc_be_d    = 4'b1111;
      acc_wdata_d = ex_store_data;
      case (ex_funct3)
         3'b000: begin
            acc_legal = 1'b1;
            if (acc_store) begin
               acc_be_d    = 4'b0001 << ex_alu_out[1:0];
               acc_wdata_d = {4{ex_store_data[7:0]}};
            end
         end
         3'b001: begin
            acc_legal = ~ex_alu_out[0];
            if (acc_store) begin
               acc_be_d    = 4'b0011 << ex_alu_out[1:0];
               acc_wdata_d = {2{ex_store_data[15:0]}};
            end
         end
         3'b010:  acc_legal = (ex_alu_out[1:0] == 2'b00);
         3'b100:  acc_legal = ~acc_store;
         3'b101:  acc_legal = ~acc_store & ~ex_alu_out[0];
         default: acc_legal = 1'b0;
      endcase

      imm_rec_d.alu      = ex_alu_out;
      imm_rec_d.reg_addr = ex_reg_addr;
      imm_rec_d.misalign = acc_mem & ~acc_legal;
      imm_rec_d.reg_we   = ex_reg_we & ~imm_rec_d.misalign;
   end

   // Select the addressed lane of the read word and extend it to 32 bits.
   always_comb begin
      lane_d = dmem_rdata >> {addr_q[1:0], 3'b000};
      case (f3_q)
         3'b000:  ld_data_d = {{24{lane_d[7]}}, lane_d[7:0]};
         3'b100:  ld_data_d = {24'd0, lane_d[7:0]};
         3'b001:  ld_data_d = {{16{lane_d[15]}}, lane_d[15:0]};
         3'b101:  ld_data_d = {16'd0, lane_d[15:0]};
         default: ld_data_d = dmem_rdata;
      endcase
   end

   // IDLE/BUSY controller with all bus and pre_wb outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         addr_q         <= '0;
         f3_q           <= '0;
         is_load_q      <= 1'b0;
         cap_reg_we_q   <= 1'b0;
         cap_reg_addr_q <= '0;
         pend_q         <= 1'b0;
         pend_rec_q     <= '0;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= '0;
         dmem_be_q      <= '0;
         dmem_wdata_q   <= '0;
         out_valid_q    <= 1'b0;
         mem_re_q       <= 1'b0;
         reg_we_q       <= 1'b0;
         misalign_q     <= 1'b0;
         bus_err_q      <= 1'b0;
         alu_out_q      <= '0;
         mem_data_out_q <= '0;
         reg_addr_q     <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments; a later assignment in this block overrides an earlier one for the same edge.
         out_valid_q <= 1'b0;
         mem_re_q    <= 1'b0;
         reg_we_q    <= 1'b0;
         misalign_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         pend_q      <= 1'b0;

         // An instruction parked behind a retiring access goes out now.
         if (pend_q) begin
            out_valid_q <= 1'b1;
            alu_out_q   <= pend_rec_q.alu;
            reg_we_q    <= pend_rec_q.reg_we;
            reg_addr_q  <= pend_rec_q.reg_addr;
            misalign_q  <= pend_rec_q.misalign;
         end

         if (state_q == S_BUSY) begin
            if (dmem_ack) begin
               state_q     <= S_IDLE;
               dmem_req_q  <= 1'b0;
               out_valid_q <= 1'b1;
               mem_re_q    <= is_load_q;
               reg_we_q    <= cap_reg_we_q & is_load_q;
               alu_out_q   <= addr_q;
               reg_addr_q  <= cap_reg_addr_q;
               if (is_load_q) mem_data_out_q <= ld_data_d;
            end else if (cnt_q == TO_LAST) begin
               state_q     <= S_IDLE;
               dmem_req_q  <= 1'b0;
               out_valid_q <= 1'b1;
               bus_err_q   <= 1'b1;
               alu_out_q   <= addr_q;
               reg_addr_q  <= cap_reg_addr_q;
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
         end

         if (accept) begin
            if (acc_mem && acc_legal) begin
               state_q        <= S_BUSY;
               cnt_q          <= '0;
               dmem_req_q     <= 1'b1;
               dmem_we_q      <= acc_store;
               dmem_addr_q    <= {ex_alu_out[31:2], 2'b00};
               dmem_be_q      <= acc_be_d;
               dmem_wdata_q   <= acc_wdata_d;
               addr_q         <= ex_alu_out;
               f3_q           <= ex_funct3;
               is_load_q      <= ex_mem_re;
               cap_reg_we_q   <= ex_reg_we;
               cap_reg_addr_q <= ex_reg_addr;
            end else if (busy_done) begin
               // The retiring access owns next cycle's output slot.
               pend_q     <= 1'b1;
               pend_rec_q <= imm_rec_d;
            end else begin
               out_valid_q <= 1'b1;
               alu_out_q   <= imm_rec_d.alu;
               reg_we_q    <= imm_rec_d.reg_we;
               reg_addr_q  <= imm_rec_d.reg_addr;
               misalign_q  <= imm_rec_d.misalign;
            end
         end
      end
   end

   assign dmem_req     = dmem_req_q;
   assign dmem_we      = dmem_we_q;
   assign dmem_addr    = dmem_addr_q;
   assign dmem_be      = dmem_be_q;
   assign dmem_wdata   = dmem_wdata_q;
   assign out_valid    = out_valid_q;
   assign mem_re       = mem_re_q;
   assign reg_we       = reg_we_q;
   assign alu_out      = alu_out_q;
   assign mem_data_out = mem_data_out_q;
   assign reg_addr     = reg_addr_q;
   assign misalign_err = misalign_q;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: expected retirements are queued when
// an instruction is issued and compared whenever out_valid pulses.
module tb_mem_access;

   logic        clk, rst;
   logic        ex_valid, ex_ready, ex_mem_re, ex_mem_we, ex_reg_we;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu_out, ex_store_data;
   logic [4:0]  ex_reg_addr;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        out_valid, mem_re, reg_we, misalign_err, bus_err;
   logic [31:0] alu_out, mem_data_out;
   logic [4:0]  reg_addr;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] md;
      logic        mem_re;
      logic        reg_we;
      logic [4:0]  rd;
      logic        mis;
      logic        berr;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   mem_access #(.ACK_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_funct3(ex_funct3),
      .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
      .ex_reg_we(ex_reg_we), .ex_reg_addr(ex_reg_addr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack),
      .out_valid(out_valid), .mem_re(mem_re), .reg_we(reg_we),
      .alu_out(alu_out), .mem_data_out(mem_data_out), .reg_addr(reg_addr),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   function automatic void push_exp(input logic [31:0] alu, input logic [31:0] md,
                                    input logic mre, input logic rwe, input logic [4:0] rd,
                                    input logic mis, input logic berr);
      exp_t e;
      e.alu = alu; e.md = md; e.mem_re = mre; e.reg_we = rwe;
      e.rd = rd; e.mis = mis; e.berr = berr;
      exp_q.push_back(e);
   endfunction

   // Scoreboard: every out_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("ret_misalign", {31'd0, misalign_err}, {31'd0, mon_e.mis});
               check("ret_bus_err", {31'd0, bus_err}, {31'd0, mon_e.berr});
               check("ret_reg_we", {31'd0, reg_we}, {31'd0, mon_e.reg_we});
               check("ret_mem_re", {31'd0, mem_re}, {31'd0, mon_e.mem_re});
               if (!mon_e.mis && !mon_e.berr) begin
                  check("ret_alu_out", alu_out, mon_e.alu);
                  check("ret_reg_addr", {27'd0, reg_addr}, {27'd0, mon_e.rd});
                  if (mon_e.mem_re) check("ret_mem_data", mem_data_out, mon_e.md);
               end
            end
         end else begin
            check("idle_flags", {28'd0, reg_we, mem_re, misalign_err, bus_err}, 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction and hold it until accepted; returns just after the accepting edge.
   task automatic issue(input logic re, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic rwe, input logic [4:0] rd);
      bit ok = 1'b0;
      ex_valid = 1'b1; ex_mem_re = re; ex_mem_we = we; ex_funct3 = f3;
      ex_alu_out = a; ex_store_data = sd; ex_reg_we = rwe; ex_reg_addr = rd;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ex_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("accept_timeout", {31'd0, ex_ready}, 32'd1);
      step();
      ex_valid = 1'b0;
   endtask

   task automatic bus_chk(input logic [31:0] e_addr, input logic e_we,
                          input logic [3:0] e_be, input logic [31:0] e_wd);
      check("bus_addr", dmem_addr, e_addr);
      check("bus_we", {31'd0, dmem_we}, {31'd0, e_we});
      check("bus_be", {28'd0, dmem_be}, {28'd0, e_be});
      if (e_we) check("bus_wdata", dmem_wdata, e_wd);
   endtask

   // Respond to an outstanding request: n_wait silent BUSY cycles, then ack.
   task automatic serve(input int n_wait, input logic [31:0] rdata,
                        input logic [31:0] e_addr, input logic e_we,
                        input logic [3:0] e_be, input logic [31:0] e_wd);
      for (int i = 0; i < n_wait; i++) begin
         @(negedge clk);
         check("req_hold", {31'd0, dmem_req}, 32'd1);
         check("busy_stall", {31'd0, ex_ready}, 32'd0);
         bus_chk(e_addr, e_we, e_be, e_wd);
      end
      @(negedge clk);
      check("req_at_ack", {31'd0, dmem_req}, 32'd1);
      bus_chk(e_addr, e_we, e_be, e_wd);
      dmem_ack = 1'b1;
      dmem_rdata = rdata;
      #1 check("exit_ready", {31'd0, ex_ready}, 32'd1);
      step();
      dmem_ack = 1'b0;
      dmem_rdata = 32'd0;
      @(negedge clk);
      check("req_drop", {31'd0, dmem_req}, 32'd0);
      check("ret_latency", {31'd0, out_valid}, 32'd1);
      step();
   endtask

   task automatic miss(input logic re, input logic we, input logic [2:0] f3, input logic [31:0] a);
      push_exp(a, 32'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
      issue(re, we, f3, a, 32'h5555_5555, 1'b1, 5'd3);
      @(negedge clk);
      check("mis_latency", {31'd0, out_valid}, 32'd1);
      check("mis_no_req", {31'd0, dmem_req}, 32'd0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; ex_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_funct3 = 3'd0;
      ex_alu_out = 32'd0; ex_store_data = 32'd0; ex_reg_we = 1'b0; ex_reg_addr = 5'd0;
      dmem_ack = 1'b0; dmem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ctrl", {25'd0, dmem_req, dmem_we, out_valid, misalign_err, bus_err, mem_re, reg_we}, 32'd0);
      check("rst_dmem_addr", dmem_addr, 32'd0);
      check("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
      check("rst_dmem_wdata", dmem_wdata, 32'd0);
      check("rst_alu_out", alu_out, 32'd0);
      check("rst_mem_data", mem_data_out, 32'd0);
      check("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'd0, ex_ready}, 32'd1);
      step();

      // ADD: non-memory result retires the next cycle
      push_exp(32'h0000_1234, 32'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 1'b1, 5'd5);
      @(negedge clk);
      check("add_latency", {31'd0, out_valid}, 32'd1);
      step();

      // LB / LBU at 0x103, ack after three silent BUSY cycles
      push_exp(32'h103, 32'hFFFF_FF80, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 1'b1, 5'd7);
      serve(3, 32'h80FF_0000, 32'h100, 1'b0, 4'b1111, 32'd0);
      push_exp(32'h103, 32'h0000_0080, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 1'b1, 5'd8);
      serve(3, 32'h80FF_0000, 32'h100, 1'b0, 4'b1111, 32'd0);

      // Stores: SH, SB, SW with lane-replicated data
      push_exp(32'h202, 32'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 1'b1, 5'd9);
      serve(1, 32'd0, 32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD);
      push_exp(32'h201, 32'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_5678, 1'b1, 5'd9);
      serve(0, 32'd0, 32'h200, 1'b1, 4'b0010, 32'h7878_7878);
      push_exp(32'h300, 32'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 1'b1, 5'd9);
      serve(2, 32'd0, 32'h300, 1'b1, 4'b1111, 32'hCAFE_F00D);

      // Half and word loads; word ack lands on the last cycle before timeout
      push_exp(32'h102, 32'hFFFF_8001, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 1'b1, 5'd4);
      serve(0, 32'h8001_0000, 32'h100, 1'b0, 4'b1111, 32'd0);
      push_exp(32'h102, 32'h0000_8001, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 1'b1, 5'd4);
      serve(1, 32'h8001_0000, 32'h100, 1'b0, 4'b1111, 32'd0);
      push_exp(32'h104, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 1'b1, 5'd6);
      serve(15, 32'hDEAD_BEEF, 32'h104, 1'b0, 4'b1111, 32'd0);

      // Load and store both set: behaves as a load
      push_exp(32'h108, 32'h0123_4567, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
      issue(1'b1, 1'b1, 3'b010, 32'h108, 32'hFFFF_FFFF, 1'b1, 5'd2);
      serve(0, 32'h0123_4567, 32'h108, 1'b0, 4'b1111, 32'd0);

      // Misaligned and illegal accesses
      miss(1'b1, 1'b0, 3'b010, 32'h101);
      miss(1'b1, 1'b0, 3'b001, 32'h103);
      miss(1'b1, 1'b0, 3'b011, 32'h100);
      miss(1'b0, 1'b1, 3'b100, 32'h100);
      miss(1'b0, 1'b1, 3'b001, 32'h201);

      // Ack never arrives: request held 16 cycles, then bus error
      push_exp(32'h400, 32'd0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1);
      issue(1'b1, 1'b0, 3'b010, 32'h400, 32'd0, 1'b1, 5'd1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!dmem_req) break;
         n++;
         check("to_ready", {31'd0, ex_ready}, (n == 16) ? 32'd1 : 32'd0);
      end
      check("to_req_cycles", n, 32'd16);
      check("to_ret", {31'd0, out_valid}, 32'd1);
      check("to_ready_back", {31'd0, ex_ready}, 32'd1);
      step();

      // Back-to-back: ADD accepted in the ack cycle retires one cycle later
      push_exp(32'h110, 32'h1111_2222, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 3'b010, 32'h110, 32'd0, 1'b1, 5'd10);
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
      push_exp(32'h55, 32'd0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b0);
      ex_valid = 1'b1; ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_funct3 = 3'b000;
      ex_alu_out = 32'h55; ex_reg_we = 1'b1; ex_reg_addr = 5'd11;
      #1 check("b2b_ready", {31'd0, ex_ready}, 32'd1);
      step();
      dmem_ack = 1'b0; ex_valid = 1'b0;
      @(negedge clk);
      check("b2b_ret_load", {31'd0, out_valid}, 32'd1);
      check("b2b_parked_stall", {31'd0, ex_ready}, 32'd0);
      @(negedge clk);
      check("b2b_ret_add", {31'd0, out_valid}, 32'd1);
      check("b2b_ready_again", {31'd0, ex_ready}, 32'd1);
      step();

      // Back-to-back loads: second accepted on the first one's ack
      push_exp(32'h120, 32'hAAAA_5555, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 3'b010, 32'h120, 32'd0, 1'b1, 5'd12);
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'hAAAA_5555;
      push_exp(32'h124, 32'h0BAD_F00D, 1'b1, 1'b1, 5'd13, 1'b0, 1'b0);
      ex_valid = 1'b1; ex_mem_re = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
      ex_alu_out = 32'h124; ex_reg_we = 1'b1; ex_reg_addr = 5'd13;
      #1 check("b2b_ld_ready", {31'd0, ex_ready}, 32'd1);
      step();
      dmem_ack = 1'b0; ex_valid = 1'b0;
      serve(0, 32'h0BAD_F00D, 32'h124, 1'b0, 4'b1111, 32'd0);

      // Reset in the second BUSY cycle discards the load
      issue(1'b1, 1'b0, 3'b010, 32'h500, 32'd0, 1'b1, 5'd14);
      @(negedge clk);
      check("rb_req_busy1", {31'd0, dmem_req}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      step();
      @(negedge clk);
      check("rb_ctrl", {25'd0, dmem_req, dmem_we, out_valid, misalign_err, bus_err, mem_re, reg_we}, 32'd0);
      check("rb_alu_out", alu_out, 32'd0);
      check("rb_mem_data", mem_data_out, 32'd0);
      check("rb_dmem_addr", dmem_addr, 32'd0);
      check("rb_ready", {31'd0, ex_ready}, 32'd1);
      step();
      rst = 1'b0;
      push_exp(32'h77, 32'd0, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 3'b000, 32'h77, 32'd0, 1'b1, 5'd15);
      @(negedge clk);
      check("rb_next_ret", {31'd0, out_valid}, 32'd1);
      step();

      repeat (3) step();
      check("sb_drain", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
